// File: rtl/boolean_min_pkg.sv
// Purpose: shared types, bit positions and golden SOP forms for the Boolean-minimisation sweeper.
// Latency: n/a (package only).
// Backpressure: n/a.
package boolean_min_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bit positions of each literal inside the 8-bit test vector.
    localparam int A_BIT = 7;
    localparam int B_BIT = 6;
    localparam int C_BIT = 5;
    localparam int D_BIT = 4;
    localparam int W_BIT = 3;
    localparam int X_BIT = 2;
    localparam int Y_BIT = 1;
    localparam int Z_BIT = 0;

    // Settle counter width; covers SETTLE_CYCLES up to 15.
    localparam int SETTLE_W = 4;

    // Unminimised f1 over a,b,c,d.
    function automatic logic g1_fn(input logic [7:0] v);
        logic a, b, c, d;
        a = v[A_BIT];
        b = v[B_BIT];
        c = v[C_BIT];
        d = v[D_BIT];
        return (~a & ~b & ~c & ~d) | (a & ~c & ~d) | (~b & c & ~d) |
               (~a & b & c & d) | (b & ~c & d);
    endfunction

    // Unminimised f2 over w,x,y,z.
    function automatic logic g2_fn(input logic [7:0] v);
        logic w, x, y, z;
        w = v[W_BIT];
        x = v[X_BIT];
        y = v[Y_BIT];
        z = v[Z_BIT];
        return (x & ~y & z) | (~x & ~y & z) | (~w & x & y) |
               (w & ~x & y) | (w & x & y);
    endfunction

endpackage

// File: rtl/golden_sop_ref.sv
// Purpose: combinational golden reference for f1/f2 from the unminimised SOP forms.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows vec every cycle.
// Ports: vec [7:0] = {a,b,c,d,w,x,y,z}; g1/g2 = reference outputs.
module golden_sop_ref
    import boolean_min_pkg::*;
(
    input  logic [7:0] vec,
    output logic       g1,
    output logic       g2
);

    assign g1 = g1_fn(vec);
    assign g2 = g2_fn(vec);

endmodule

// File: rtl/boolean_min_sweeper.sv
// Purpose: exhaustive 256-vector sweep of a minimised block, checked against the golden SOP forms.
// Latency: SETTLE_CYCLES+1 cycles per vector; done rises 256*(SETTLE_CYCLES+1) cycles after start.
// Backpressure: none; start while busy is ignored, results held in DONE until next start or rst.
// Ports: clk/rst (sync, active-high); start pulse; vec_out drives the block under test;
//        f1_in/f2_in return from it; busy/done/pass/err_count/first_err_valid/first_err_idx report.
module boolean_min_sweeper
    import boolean_min_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] vec_out,
    input  logic       f1_in,
    input  logic       f2_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [8:0] err_count,
    output logic       first_err_valid,
    output logic [7:0] first_err_idx
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t              state;
    state_t              state_nxt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                g1;
    logic                g2;
    logic                mismatch;

    golden_sop_ref u_ref (
        .vec (vec_out),
        .g1  (g1),
        .g2  (g2)
    );

    // A vector with both outputs wrong still counts as a single failing vector.
    assign mismatch = (f1_in != g1) | (f2_in != g2);

    assign busy = (state == ST_DRIVE) || (state == ST_CHECK);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_nxt = (vec_out == 8'hFF) ? ST_DONE : ST_DRIVE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_out         <= 8'h00;
            settle_cnt      <= '0;
            pass            <= 1'b0;
            err_count       <= 9'd0;
            first_err_valid <= 1'b0;
            first_err_idx   <= 8'h00;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        vec_out         <= 8'h00;
                        settle_cnt      <= '0;
                        pass            <= 1'b0;
                        err_count       <= 9'd0;
                        first_err_valid <= 1'b0;
                        first_err_idx   <= 8'h00;
                    end
                end
                ST_DRIVE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
                ST_CHECK: begin
                    settle_cnt <= '0;
                    if (mismatch) begin
                        err_count <= err_count + 9'd1;
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_idx   <= vec_out;
                        end
                    end
                    if (vec_out != 8'hFF) begin
                        vec_out <= vec_out + 8'd1;
                    end else begin
                        // Final vector: pass must include this last check's outcome.
                        pass <= (err_count == 9'd0) && !mismatch;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boolean_min_sweeper.sv
module tb_boolean_min_sweeper;

    localparam int S1 = 1;
    localparam int S3 = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start3;
    logic       tie1, tie2;
    logic [7:0] vec1, vec3;
    logic       f1_1, f2_1, f1_3, f2_3;
    logic       busy1, done1, pass1, fev1;
    logic       busy3, done3, pass3, fev3;
    logic [8:0] err1, err3;
    logic [7:0] fei1, fei3;

    // Truth tables of f1 (indexed by abcd) and f2 (indexed by wxyz), derived by hand.
    logic [15:0] g1_tt = 16'h35A5;
    logic [15:0] g2_tt = 16'hEEE2;

    always #5 clk = ~clk;

    // Minimised block stand-in, with optional stuck-at-0 faults on either output.
    assign f1_1 = tie1 ? 1'b0 : g1_tt[vec1[7:4]];
    assign f2_1 = tie2 ? 1'b0 : g2_tt[vec1[3:0]];
    assign f1_3 = g1_tt[vec3[7:4]];
    assign f2_3 = g2_tt[vec3[3:0]];

    boolean_min_sweeper #(.SETTLE_CYCLES(S1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .vec_out(vec1),
        .f1_in(f1_1), .f2_in(f2_1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_valid(fev1), .first_err_idx(fei1)
    );

    boolean_min_sweeper #(.SETTLE_CYCLES(S3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .vec_out(vec3),
        .f1_in(f1_3), .f2_in(f2_3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .first_err_valid(fev3), .first_err_idx(fei3)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bad_vec(input int v);
        logic [7:0] vv;
        vv = v[7:0];
        return (tie1 && g1_tt[vv[7:4]]) || (tie2 && g2_tt[vv[3:0]]);
    endfunction

    // Cycle-by-cycle model of dut1: n = clock edges since the start edge.
    bit track = 0;
    int n = 0;

    always @(negedge clk) begin
        int  checked, exp_err, exp_first;
        bit  exp_fv;
        if (track) begin
            checked = n / (S1 + 1);
            if (checked > 256) checked = 256;
            exp_err = 0; exp_fv = 0; exp_first = 0;
            for (int v = 0; v < checked; v++) begin
                if (bad_vec(v)) begin
                    exp_err++;
                    if (!exp_fv) begin
                        exp_fv = 1;
                        exp_first = v;
                    end
                end
            end
            if (n < 256 * (S1 + 1)) begin
                chk("vec", int'(vec1), n / (S1 + 1));
                chk("busy", int'(busy1), 1);
                chk("done", int'(done1), 0);
                chk("pass_in_sweep", int'(pass1), 0);
            end else begin
                chk("vec_final", int'(vec1), 255);
                chk("busy_done", int'(busy1), 0);
                chk("done_level", int'(done1), 1);
                chk("pass_model", int'(pass1), (exp_err == 0) ? 1 : 0);
            end
            chk("err_count", int'(err1), exp_err);
            chk("first_err_valid", int'(fev1), int'(exp_fv));
            chk("first_err_idx", int'(fei1), exp_first);
            n++;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_vec"}, int'(vec1), 0);
        chk({tag, "_busy"}, int'(busy1), 0);
        chk({tag, "_done"}, int'(done1), 0);
        chk({tag, "_pass"}, int'(pass1), 0);
        chk({tag, "_err"}, int'(err1), 0);
        chk({tag, "_fev"}, int'(fev1), 0);
        chk({tag, "_fei"}, int'(fei1), 0);
    endtask

    task automatic run_sweep(input bit poke, input int exp_cycles);
        int cyc;
        bit poked;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        n = 0;
        track = 1;
        cyc = 0;
        poked = 0;
        while (!done1 && cyc < 3000) begin
            if (poke && !poked && vec1 == 8'h10) begin
                start1 = 1'b1;
                poked = 1;
            end
            @(posedge clk);
            #1;
            start1 = 1'b0;
            cyc++;
        end
        chk("done_latency", cyc, exp_cycles);
        repeat (3) @(posedge clk);
        #1;
        track = 0;
    endtask

    initial begin
        int cyc;
        bit poked;
        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; tie1 = 1'b0; tie2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;

        // Correct block, with a start pulse mid-sweep that must be ignored.
        run_sweep(1, 512);
        chk("t1_pass", int'(pass1), 1);
        chk("t1_err", int'(err1), 0);
        chk("t1_fev", int'(fev1), 0);

        // f1 stuck at 0.
        tie1 = 1'b1; tie2 = 1'b0;
        run_sweep(0, 512);
        chk("t2_err", int'(err1), 128);
        chk("t2_fei", int'(fei1), 8'h00);
        chk("t2_pass", int'(pass1), 0);

        // f2 stuck at 0.
        tie1 = 1'b0; tie2 = 1'b1;
        run_sweep(0, 512);
        chk("t3_err", int'(err1), 160);
        chk("t3_fei", int'(fei1), 8'h01);

        // Both stuck at 0, then restart from DONE with a correct block.
        tie1 = 1'b1; tie2 = 1'b1;
        run_sweep(0, 512);
        chk("t4_err", int'(err1), 208);
        chk("t4_fei", int'(fei1), 8'h00);
        tie1 = 1'b0; tie2 = 1'b0;
        run_sweep(0, 512);
        chk("t4_repass", int'(pass1), 1);
        chk("t4_reerr", int'(err1), 0);

        // rst mid-sweep at vector 0x40.
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        cyc = 0;
        while (vec1 != 8'h40 && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("t5_reach_40", int'(vec1), 8'h40);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("t5_abort");
        // start and rst together: rst wins.
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        rst = 1'b0;
        chk("t5_rst_wins_busy", int'(busy1), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("t5_idle_busy", int'(busy1), 0);
        run_sweep(0, 512);
        chk("t5_restart_pass", int'(pass1), 1);

        // SETTLE_CYCLES=3 instance, start pulsed while busy at 0x10.
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        cyc = 0;
        poked = 0;
        while (!done3 && cyc < 5000) begin
            if (!poked && vec3 == 8'h10) begin
                start3 = 1'b1;
                poked = 1;
            end
            @(posedge clk);
            #1;
            start3 = 1'b0;
            cyc++;
        end
        chk("t6_latency", cyc, 1024);
        chk("t6_poked", int'(poked), 1);
        chk("t6_pass", int'(pass3), 1);
        chk("t6_err", int'(err3), 0);
        chk("t6_vec", int'(vec3), 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
